// File: rtl/fetch_sequencer.sv
// Instruction-fetch and PC-sequencing stage feeding the decoder.
// Owns the PC, runs a req/ack handshake with instruction memory, presents the
// captured instruction to decode/execute and computes the next PC from the
// decoder's control flags. Stops on invalid instructions or misaligned jr.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/addr         fetch request and address (addr == pc)
//   imem_ack/rdata        fetch completion and instruction word
//   inst_valid, inst      captured instruction presented to decode
//   opcode, funct         inst[31:26], inst[5:0]
//   pc, pc_plus4          address of presented instruction, and pc+4
//   branch_eq/neq, jump,
//   jump_reg, invalid_inst decoder flags for the presented instruction
//   alu_zero, imm_ext,
//   rs_data               operands for branch/jump target selection
//   stall                 hold the presented instruction
//   halted, fault_code    stopped flag and cause (01 invalid, 10 misaligned jr)
//   inst_count            retired instruction count
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_eq,
  input  logic        branch_neq,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        invalid_inst,
  input  logic        alu_zero,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        halted,
  output logic [1:0]  fault_code,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {StBoot, StReq, StExec, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] count_q;
  logic [1:0]  fault_q;

  logic        branch_taken;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_taken  = (branch_eq & alu_zero) | (branch_neq & ~alu_zero);
    jump_target   = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    branch_target = pc_plus4 + (imm_ext << 2);
    // Priority: jr, then j/jal, then taken branch, else sequential.
    if (jump_reg) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      count_q <= 32'h0;
      fault_q <= 2'b00;
    end else begin
      case (state_q)
        StBoot: state_q <= StReq;
        StReq: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            state_q <= StExec;
          end
        end
        StExec: begin
          // Decoder flags only matter in the cycle the stall drops.
          if (!stall) begin
            if (invalid_inst) begin
              state_q <= StHalt;
              fault_q <= 2'b01;
            end else if (jump_reg && (rs_data[1:0] != 2'b00)) begin
              state_q <= StHalt;
              fault_q <= 2'b10;
            end else begin
              pc_q    <= next_pc;
              count_q <= count_q + 32'd1;
              state_q <= StReq;
            end
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StBoot;
      endcase
    end
  end

  // Handshake/status outputs depend on the state register alone.
  assign imem_req   = (state_q == StReq);
  assign inst_valid = (state_q == StExec);
  assign halted     = (state_q == StHalt);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign opcode     = inst_q[31:26];
  assign funct      = inst_q[5:0];
  assign fault_code = fault_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected fetches and
// retirements into queues; a monitor pops and compares on each handshake.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_eq, branch_neq, jump, jump_reg, invalid_inst, alu_zero;
  logic [31:0] imm_ext;
  logic [31:0] rs_data;
  logic        stall;
  logic        halted;
  logic [1:0]  fault_code;
  logic [31:0] inst_count;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .opcode(opcode), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4),
    .branch_eq(branch_eq), .branch_neq(branch_neq), .jump(jump),
    .jump_reg(jump_reg), .invalid_inst(invalid_inst), .alu_zero(alu_zero),
    .imm_ext(imm_ext), .rs_data(rs_data), .stall(stall),
    .halted(halted), .fault_code(fault_code), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // Decoder flag bits for run_inst
  localparam logic [5:0] FZero = 6'b000001;
  localparam logic [5:0] FBeq  = 6'b000010;
  localparam logic [5:0] FBne  = 6'b000100;
  localparam logic [5:0] FJ    = 6'b001000;
  localparam logic [5:0] FJr   = 6'b010000;
  localparam logic [5:0] FInv  = 6'b100000;

  localparam logic [31:0] Addi = 32'h2008_0005;
  localparam logic [31:0] Jr   = 32'h03E0_0008;

  typedef struct {
    logic [31:0] addr;
    int          cycles;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] count;
  } retire_t;

  fetch_t      fetch_q[$];
  retire_t     retire_q[$];
  int          total  = 0;
  int          passed = 0;
  int          req_run = 0;
  logic [31:0] exp_count = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_eq = 1'b0; branch_neq = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    invalid_inst = 1'b0; alu_zero = 1'b0; imm_ext = 32'h0; rs_data = 32'h0;
  endtask

  // Monitor: compare on fetch handshakes and on un-stalled EXEC cycles.
  always @(negedge clk) begin
    fetch_t  f;
    retire_t r;
    if (!rst_n) begin
      req_run = 0;
    end else begin
      if (imem_req) begin
        req_run++;
        if (imem_ack) begin
          if (fetch_q.size() == 0) begin
            total++;
            $display("FAIL fetch_unexpected: addr %h with nothing queued", imem_addr);
          end else begin
            f = fetch_q.pop_front();
            check("fetch_addr", imem_addr, f.addr);
            check("fetch_req_cycles", req_run, f.cycles);
            check("fetch_no_valid", {31'h0, inst_valid}, 32'h0);
          end
          req_run = 0;
        end
      end else begin
        req_run = 0;
      end
      if (inst_valid && !stall) begin
        if (retire_q.size() == 0) begin
          total++;
          $display("FAIL retire_unexpected: pc %h with nothing queued", pc);
        end else begin
          r = retire_q.pop_front();
          check("retire_pc", pc, r.pc);
          check("retire_inst", inst, r.word);
          check("retire_opcode", {26'h0, opcode}, {26'h0, r.word[31:26]});
          check("retire_funct", {26'h0, funct}, {26'h0, r.word[5:0]});
          check("retire_pc_plus4", pc_plus4, r.pc + 32'd4);
          check("retire_count", inst_count, r.count);
        end
      end
    end
  end

  // Fetch one instruction at addr after lat wait cycles, optionally stall,
  // then release with the given decoder flags.
  task automatic run_inst(input logic [31:0] addr, input logic [31:0] word, input int lat,
                          input logic [5:0] fl, input logic [31:0] imm, input logic [31:0] rs,
                          input int stalls);
    int n = 0;
    fetch_q.push_back('{addr: addr, cycles: lat + 1});
    retire_q.push_back('{pc: addr, word: word, count: exp_count});
    while (!imem_req && n < 8) begin
      step();
      n++;
    end
    if (!imem_req) begin
      total++;
      $display("FAIL req_timeout: imem_req %b expected 1 for addr %h", imem_req, addr);
      void'(fetch_q.pop_back());
      void'(retire_q.pop_back());
      return;
    end
    repeat (lat) step();
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      branch_eq = (i % 2 == 0);
      alu_zero = 1'b1;
      imm_ext = 32'h10;
      check("stall_valid", {31'h0, inst_valid}, 32'h1);
      check("stall_pc", pc, addr);
      step();
    end
    stall = 1'b0;
    alu_zero = fl[0]; branch_eq = fl[1]; branch_neq = fl[2];
    jump = fl[3]; jump_reg = fl[4]; invalid_inst = fl[5];
    imm_ext = imm; rs_data = rs;
    step();
    clear_inputs();
    if (!fl[5] && !(fl[4] && rs[1:0] != 2'b00)) exp_count++;
  endtask

  task automatic check_reset_state();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_count", inst_count, 32'h0);
    check("rst_fault", {30'h0, fault_code}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_reset_state();
    rst_n = 1'b1;

    // Back-to-back addi with same-cycle ack
    run_inst(32'h0, Addi, 0, 6'b0, 32'h0, 32'h0, 0);
    run_inst(32'h4, Addi, 0, 6'b0, 32'h0, 32'h0, 0);
    run_inst(32'h8, Addi, 0, 6'b0, 32'h0, 32'h0, 0);
    check("count_after_three", inst_count, 32'd3);
    run_inst(32'hC, 32'h0, 0, 6'b0, 32'h0, 32'h0, 0);
    // Ack latency of three cycles
    run_inst(32'h10, 32'h2009_0007, 3, 6'b0, 32'h0, 32'h0, 0);
    // j to 0x20
    run_inst(32'h14, 32'h0800_0008, 0, FJ, 32'h0, 32'h0, 0);
    // beq taken backwards: 0x24 - 8 = 0x1C
    run_inst(32'h20, 32'h1000_FFFE, 0, FBeq | FZero, 32'hFFFF_FFFE, 32'h0, 0);
    run_inst(32'h1C, 32'h0800_0008, 0, FJ, 32'h0, 32'h0, 0);
    // bne with zero set: not taken
    run_inst(32'h20, 32'h1400_FFFE, 0, FBne | FZero, 32'hFFFF_FFFE, 32'h0, 0);
    // Five stall cycles with branch_eq toggling, released not-taken
    run_inst(32'h24, 32'h1000_0004, 0, FZero, 32'h10, 32'h0, 5);
    // jr to top of memory, then PC wraps to 0
    run_inst(32'h28, Jr, 0, FJr, 32'h0, 32'hFFFF_FFFC, 0);
    run_inst(32'hFFFF_FFFC, 32'h0, 0, 6'b0, 32'h0, 32'h0, 0);
    // jr wins over j and taken beq
    run_inst(32'h0, Jr, 0, FJr | FJ | FBeq | FZero, 32'h4, 32'h4000_0000, 0);
    run_inst(32'h4000_0000, 32'h0800_0010, 0, FJ, 32'h0, 32'h0, 0);
    run_inst(32'h4000_0040, 32'h0800_0000, 0, FJ, 32'h0, 32'h0, 0);
    // Misaligned jr halts
    run_inst(32'h4000_0000, Jr, 0, FJr, 32'h0, 32'h0000_0102, 0);
    check("jr_halted", {31'h0, halted}, 32'h1);
    check("jr_fault", {30'h0, fault_code}, 32'h2);
    check("jr_req", {31'h0, imem_req}, 32'h0);
    check("jr_valid", {31'h0, inst_valid}, 32'h0);
    check("jr_pc", pc, 32'h4000_0000);
    check("jr_count", inst_count, 32'd15);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (3) step();
    check("halt_sticky", {31'h0, halted}, 32'h1);
    check("halt_inst_kept", inst, Jr);
    clear_inputs();

    // Invalid instruction after a fresh reset
    rst_n = 1'b0;
    step();
    step();
    check_reset_state();
    rst_n = 1'b1;
    exp_count = 32'h0;
    run_inst(32'h0, 32'hFC00_0000, 0, FInv, 32'h0, 32'h0, 0);
    check("inv_halted", {31'h0, halted}, 32'h1);
    check("inv_fault", {30'h0, fault_code}, 32'h1);
    check("inv_count", inst_count, 32'h0);
    check("inv_pc", pc, 32'h0);
    // One-edge reset with ack asserted: the ack must be ignored
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    imem_ack = 1'b0;
    check_reset_state();
    run_inst(32'h0, Addi, 0, 6'b0, 32'h0, 32'h0, 0);
    check("resume_count", inst_count, 32'd1);
    step();
    check("fetch_q_drained", fetch_q.size(), 32'h0);
    check("retire_q_drained", retire_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
